dcache_arbiter: RTL
===================

Name: dcache_arbiter

Overview:
- Shares the single-port 32-entry data cache between NUM_REQ requesters, e.g. the execute stage (req 0) and the debug/load port (req 1).
- Accepts valid/ready requests and arbitrates between them round-robin or by fixed priority.
- Registers the winning command into the cache's addr/data_in/uop inputs and returns read data with a tagged response.
- Supports a lock so one requester can perform atomic read-modify-write sequences.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 5, cache word address width.
- DATA_W, 32, data width.
- FIXED_PRIO, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; transfer when valid&ready at posedge.
- req_write  in  NUM_REQ  1 = store (STR), 0 = load (LDR).
- req_lock  in  NUM_REQ  hold the grant after this transfer.
- req_addr  in  NUM_REQ x ADDR_W  word address.
- req_wdata  in  NUM_REQ x DATA_W  store data.
- resp_valid  out  NUM_REQ  one-cycle response pulse to the originating requester.
- resp_rdata  out  DATA_W  load data, shared bus, qualified by resp_valid.
- cache_addr  out  ADDR_W  to cache addr (registered).
- cache_wdata  out  DATA_W  to cache data_in (registered).
- cache_uop  out  Uop  to cache uop (registered): LDR, STR or NOP.
- cache_rdata  in  DATA_W  from cache data_out.

Behaviour:
- Reset values (async assert):
  - req_ready=0, resp_valid=0.
  - cache_addr=0, cache_wdata=0, cache_uop=NOP.
  - rr pointer=0, state=ARB, lock owner=0, response pipeline tags cleared.
  - Reset mid-operation drops in-flight responses; no resp_valid appears after deassertion for pre-reset requests.
- Throughput: one transfer per cycle; no back-pressure from the cache.
- Pipeline (accept at posedge E0):
  - E0: cache_addr/cache_wdata/cache_uop load the winner's command.
  - E1: the cache samples them. LDR registers data_out at E1. STR writes on the negedge between E0 and E1.
  - E1: the response tag (valid + requester index) advances.
  - Cycle E1..E2: resp_valid[idx]=1, resp_rdata=cache_rdata.
  - Latency is 2 cycles from acceptance to response for both loads and stores.
  - Store responses carry resp_rdata=0, because the cache outputs 0 for non-LDR.
- When no transfer occurs at a posedge, cache_uop=NOP for the following cycle.
- Ordering: responses are in acceptance order. A load accepted the cycle after a store to the same address returns the new data, because the write lands on the negedge before the load's sampling edge.
- req_ready is combinational from req_valid, state and pointer. Exactly one bit is set when any eligible requester is valid; it is never set for a non-valid requester.
- State ARB:
  - Round-robin: search starts at the rr pointer. After a transfer, pointer = winner+1 mod NUM_REQ; with no transfer the pointer holds.
  - FIXED_PRIO=1: lowest index wins; the pointer is unused.
  - Transfer with req_lock[w]=1 -> LOCKED, owner=w.
- State LOCKED:
  - Only the owner may be granted; other requesters see req_ready=0.
  - Owner transfer with req_lock=0 -> ARB, pointer = owner+1.
  - Owner may idle (valid=0) while locked, and the state holds.
- Simultaneous events:
  - Requests from all requesters in the same cycle: exactly one is granted.
  - A response for an earlier request and a new acceptance in the same cycle are independent.
- req_write/addr/wdata are sampled only on transfer. Address is exact ADDR_W bits; there is no wrap logic.

Decomposition:
- Package Utilities already holds the Uop enum. Add the NOP member there if absent.
- Add a localparam for the state enum (ARB, LOCKED) to Utilities as typedef ArbState.
- Sub-module rr_picker: combinational, takes valid vector, pointer and fixed-priority flag; returns one-hot grant and encoded index. It is reused by future shared-resource arbiters.

Test Plan:
- Single load: preload addr 3 = 0xDEADBEEF via req0 store; req0 load addr 3 -> resp_valid[0] exactly 2 cycles after accept, resp_rdata=0xDEADBEEF, cache_uop LDR for one cycle.
- Contention, round-robin: req0 and req1 valid every cycle for 6 cycles, loads -> grants alternate 0,1,0,1,0,1; responses arrive in the same order, each 2 cycles later.
- Fixed priority: FIXED_PRIO=1, both valid for 4 cycles -> req0 granted all 4; req1 granted on the first cycle req0 drops valid.
- Lock: req1 store addr 7 with lock=1, then req1 load addr 7 with lock=0, req0 valid throughout -> req0 req_ready=0 for both cycles, req1 load returns the stored value, then req0 is granted.
- Store-to-load back-to-back: req0 store addr 10 = 0x12345678, next cycle load addr 10 -> resp_rdata=0x12345678; store response rdata=0.
- Reset mid-operation: assert reset one cycle after accepting a load -> outputs at reset values immediately (async); no resp_valid after deassertion; first post-reset grant goes to req0.

Source files
------------

// File: rtl/dcache_arbiter_pkg.sv
// Shared types for the data-cache arbiter: cache micro-ops, arbiter states
// and the response tag carried through the two-stage pipeline.
package Utilities;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    LDR = 2'd1,
    STR = 2'd2
  } Uop;

  typedef logic [0:0] ArbState;
  localparam ArbState ARB    = 1'b0;
  localparam ArbState LOCKED = 1'b1;

  // Requester index width sized for the largest supported requester count (4).
  localparam int unsigned REQ_IDX_W = 2;

  typedef struct packed {
    logic                 valid;
    logic [REQ_IDX_W-1:0] idx;
  } resp_tag_t;

  // Index + 1, wrapping at n.
  function automatic logic [REQ_IDX_W-1:0] wrap_inc(input logic [REQ_IDX_W-1:0] idx,
                                                    input int unsigned n);
    return ((32'(idx) + 32'd1) >= n) ? '0 : idx + REQ_IDX_W'(1);
  endfunction

endpackage

// File: rtl/dcache_arbiter_rr_picker.sv
// One-hot picker: first valid requester searching upward from ptr (round-robin)
// or from index 0 (fixed priority). Purely combinational.
module rr_picker
  import Utilities::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]   valid,
  input  logic [REQ_IDX_W-1:0] ptr,
  input  logic                 fixed,
  output logic [NUM_REQ-1:0]   grant,
  output logic [REQ_IDX_W-1:0] idx,
  output logic                 any
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = fixed ? i : ((32'(ptr) + i) % NUM_REQ);
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!any && (j == cand) && valid[j]) begin
          any      = 1'b1;
          grant[j] = 1'b1;
          idx      = REQ_IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/dcache_arbiter.sv
// Arbitrates NUM_REQ valid/ready requesters onto the single-port data cache,
// registers the winning command and returns a tagged response two cycles later.
module dcache_arbiter
  import Utilities::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [DATA_W-1:0]              resp_rdata,
  output logic [ADDR_W-1:0]              cache_addr,
  output logic [DATA_W-1:0]              cache_wdata,
  output Uop                             cache_uop,
  input  logic [DATA_W-1:0]              cache_rdata
);

  ArbState              state, state_nxt;
  logic [REQ_IDX_W-1:0] ptr, ptr_nxt;
  logic [REQ_IDX_W-1:0] owner, owner_nxt;
  logic [NUM_REQ-1:0]   pick_valid;
  logic [NUM_REQ-1:0]   grant;
  logic [REQ_IDX_W-1:0] pick_idx;
  logic                 pick_any;
  logic                 xfer;
  logic                 lock_w;
  logic                 write_w;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  resp_tag_t            tag;

  // While locked, only the owner is visible to the picker.
  assign pick_valid = (state == LOCKED) ? (req_valid & (NUM_REQ'(1) << owner)) : req_valid;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid (pick_valid),
    .ptr   (ptr),
    .fixed (FIXED_PRIO),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready  = reset ? '0 : grant;
  assign xfer       = pick_any && !reset;
  assign lock_w     = |(req_lock & grant);
  assign write_w    = |(req_write & grant);
  assign resp_rdata = cache_rdata;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        sel_addr  = req_addr[j];
        sel_wdata = req_wdata[j];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    case (state)
      ARB: begin
        if (xfer) begin
          ptr_nxt = wrap_inc(pick_idx, NUM_REQ);
          if (lock_w) begin
            state_nxt = LOCKED;
            owner_nxt = pick_idx;
          end
        end
      end
      LOCKED: begin
        // A locked transfer keeps the grant; the pointer moves only on release.
        if (xfer && !lock_w) begin
          state_nxt = ARB;
          ptr_nxt   = wrap_inc(owner, NUM_REQ);
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Cache command register and response tag pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cache_addr  <= '0;
      cache_wdata <= '0;
      cache_uop   <= NOP;
      tag         <= '0;
      resp_valid  <= '0;
    end else begin
      if (xfer) begin
        cache_addr  <= sel_addr;
        cache_wdata <= sel_wdata;
        cache_uop   <= write_w ? STR : LDR;
      end else begin
        cache_uop   <= NOP;
      end
      tag        <= '{valid: xfer, idx: pick_idx};
      resp_valid <= tag.valid ? (NUM_REQ'(1) << tag.idx) : '0;
    end
  end

endmodule
